// File: rtl/comm_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// default sizing that must agree with the downstream FIFO's FIFO_WIDTH.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACTIVE   = 2'b01,
        THROTTLE = 2'b10
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_FIFO_WIDTH = 16;
    localparam int DEFAULT_STAT_WIDTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter, bundled so the
// arbiter sees them as one port (slave) and the surrounding logic drives them (master).
interface fifo_wr_arbiter_if
    import comm_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH
) ();

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 gnt;
    logic                               fifo_full;
    logic                               fifo_almostfull;
    logic                               fifo_wr_en;
    logic [FIFO_WIDTH-1:0]              fifo_data_in;

    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull,
        output gnt, fifo_wr_en, fifo_data_in
    );

    modport master (
        output req, req_data, fifo_full, fifo_almostfull,
        input  gnt, fifo_wr_en, fifo_data_in
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req after last_gnt, wrapping,
// returned both one-hot and as a binary index. Nothing is picked while enable is low.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        if (enable) begin
            // Offsets 1..NUM_REQ so the previous winner is considered last.
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand = (int'(last_gnt) + i) % NUM_REQ;
                if (!found && req[IDX_W'(cand)]) begin
                    found                = 1'b1;
                    gnt[IDX_W'(cand)]    = 1'b1;
                    gnt_idx              = IDX_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with
// back-pressure throttling. Define FIFO_WR_ARB_STATS_EN to add saturating grant counters.
module fifo_wr_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int STAT_WIDTH = DEFAULT_STAT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [NUM_REQ-1:0][STAT_WIDTH-1:0] grant_cnt,
`endif
    output logic [1:0]          arb_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e            state, state_next;
    logic [IDX_W-1:0]      last_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    gnt;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  stall;
    logic                  any_gnt;

    // The in-flight write counts against capacity, so almostfull stalls when a write is pending.
    assign stall   = bus.fifo_full | (wr_en_q & bus.fifo_almostfull);
    assign any_gnt = |gnt;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .enable   (!stall && !rst),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        state_next = IDLE;
        if (|bus.req) begin
            state_next = stall ? THROTTLE : ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
        end else begin
            state   <= state_next;
            wr_en_q <= any_gnt;
            if (any_gnt) begin
                data_q   <= bus.req_data[gnt_idx];
                last_gnt <= gnt_idx;
            end
        end
    end

    assign bus.gnt          = gnt;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign arb_state        = state;

`ifdef FIFO_WR_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst) begin
                grant_cnt[g] <= '0;
            end else if (gnt[g] && (grant_cnt[g] != '1)) begin
                grant_cnt[g] <= grant_cnt[g] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a queue-free round-robin reference model checks
// every cycle, and literal expectations pin the model at key points of each scenario.
module tb_fifo_wr_arbiter;
    import comm_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] arb_state;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N-1:0][SW-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .FIFO_WIDTH (W),
        .STAT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
`ifdef FIFO_WR_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .arb_state (arb_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: state of the world as seen after the most recent rising edge.
    int         m_last;
    logic       m_wr_en;
    logic [W-1:0] m_data;
    logic [1:0] m_state;
    int         m_cnt [N];
    bit         armed = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit           m_stall;
        int           win;
        int           idx;
        m_stall = bus.fifo_full || (armed && m_wr_en && bus.fifo_almostfull);
        eg  = '0;
        win = -1;
        if (!rst && !m_stall) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (win < 0 && bus.req[idx[1:0]]) win = idx;
            end
        end
        if (win >= 0) eg[win[1:0]] = 1'b1;

        if (rst || armed) check_output("model_gnt", 32'(bus.gnt), 32'(eg));
        if (armed) begin
            check_output("model_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr_en));
            check_output("model_data", 32'(bus.fifo_data_in), 32'(m_data));
            check_output("model_state", 32'(arb_state), 32'(m_state));
`ifdef FIFO_WR_ARB_STATS_EN
            for (int i = 0; i < N; i++)
                check_output("model_cnt", 32'(grant_cnt[i[1:0]]), 32'(m_cnt[i]));
`endif
        end

        if (rst) begin
            m_last  = N - 1;
            m_wr_en = 1'b0;
            m_data  = '0;
            m_state = IDLE;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            armed   = 1'b1;
        end else if (armed) begin
            m_state = (bus.req != '0) ? (m_stall ? THROTTLE : ACTIVE) : IDLE;
            m_wr_en = (win >= 0);
            if (win >= 0) begin
                m_data = bus.req_data[win[1:0]];
                m_last = win;
                if (m_cnt[win] < (1 << SW) - 1) m_cnt[win] = m_cnt[win] + 1;
            end
        end
    end

    task automatic apply_stimulus(input logic r, input logic [N-1:0] rq,
                                  input logic full, input logic afull);
        @(posedge clk);
        #1;
        rst                 = r;
        bus.req             = rq;
        bus.fifo_full       = full;
        bus.fifo_almostfull = afull;
        @(negedge clk);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.req             = '0;
        bus.fifo_full       = 1'b0;
        bus.fifo_almostfull = 1'b0;
        bus.req_data        = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        @(negedge clk);
        check_output("rst_gnt", 32'(bus.gnt), 32'h0);
        apply_stimulus(1, 4'b0000, 0, 0);

        // Reset values, idle
        apply_stimulus(0, 4'b0000, 0, 0);
        check_output("idle_state", 32'(arb_state), 32'(IDLE));
        check_output("idle_gnt", 32'(bus.gnt), 32'h0);
        check_output("idle_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check_output("idle_data", 32'(bus.fifo_data_in), 32'h0);

        // All requesting: rotation 0,1,2,3 with one-cycle write latency
        apply_stimulus(0, 4'b1111, 0, 0);
        check_output("rot_gnt0", 32'(bus.gnt), 32'b0001);
        apply_stimulus(0, 4'b1111, 0, 0);
        check_output("rot_gnt1", 32'(bus.gnt), 32'b0010);
        check_output("rot_wr0", 32'(bus.fifo_wr_en), 32'h1);
        check_output("rot_data0", 32'(bus.fifo_data_in), 32'h1111);
        check_output("rot_state", 32'(arb_state), 32'(ACTIVE));
        apply_stimulus(0, 4'b1111, 0, 0);
        check_output("rot_gnt2", 32'(bus.gnt), 32'b0100);
        check_output("rot_data1", 32'(bus.fifo_data_in), 32'h2222);
        apply_stimulus(0, 4'b1111, 0, 0);
        check_output("rot_gnt3", 32'(bus.gnt), 32'b1000);
        check_output("rot_data2", 32'(bus.fifo_data_in), 32'h3333);
        apply_stimulus(0, 4'b0000, 0, 0);
        check_output("rot_data3", 32'(bus.fifo_data_in), 32'h4444);

        // Set last_gnt=0, then alternate between requesters 2 and 0
        apply_stimulus(0, 4'b0001, 0, 0);
        check_output("alt_seed", 32'(bus.gnt), 32'b0001);
        apply_stimulus(0, 4'b0101, 0, 0);
        check_output("alt_gnt_a", 32'(bus.gnt), 32'b0100);
        apply_stimulus(0, 4'b0101, 0, 0);
        check_output("alt_gnt_b", 32'(bus.gnt), 32'b0001);
        apply_stimulus(0, 4'b0101, 0, 0);
        check_output("alt_gnt_c", 32'(bus.gnt), 32'b0100);

        // Back-pressure: almostfull with a write in flight, then full, then release
        apply_stimulus(0, 4'b0001, 0, 1);
        check_output("thr_gnt_af", 32'(bus.gnt), 32'h0);
        check_output("thr_wr_inflight", 32'(bus.fifo_wr_en), 32'h1);
        apply_stimulus(0, 4'b0001, 1, 0);
        check_output("thr_gnt_full", 32'(bus.gnt), 32'h0);
        check_output("thr_state", 32'(arb_state), 32'(THROTTLE));
        apply_stimulus(0, 4'b0001, 0, 0);
        check_output("thr_resume", 32'(bus.gnt), 32'b0001);
        apply_stimulus(0, 4'b0000, 0, 0);
        check_output("thr_data", 32'(bus.fifo_data_in), 32'h1111);

        // Almostfull alone only stalls when a write is in flight: one bubble
        apply_stimulus(0, 4'b1000, 0, 1);
        check_output("af_nostall", 32'(bus.gnt), 32'b1000);
        apply_stimulus(0, 4'b1000, 0, 1);
        check_output("af_bubble", 32'(bus.gnt), 32'h0);
        apply_stimulus(0, 4'b1000, 0, 1);
        check_output("af_regrant", 32'(bus.gnt), 32'b1000);
        apply_stimulus(0, 4'b0000, 0, 0);

        // Reset mid-grant drops the in-flight write and restores req[0] priority
        apply_stimulus(0, 4'b0010, 0, 0);
        check_output("mid_gnt", 32'(bus.gnt), 32'b0010);
        apply_stimulus(1, 4'b0010, 0, 0);
        check_output("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        apply_stimulus(0, 4'b0011, 0, 0);
        check_output("mid_wr_dropped", 32'(bus.fifo_wr_en), 32'h0);
        check_output("mid_first_gnt", 32'(bus.gnt), 32'b0001);
        apply_stimulus(0, 4'b0000, 0, 0);

        // A requester dropping out does not disturb the pointer
        apply_stimulus(0, 4'b0110, 0, 0);
        check_output("drop_gnt_a", 32'(bus.gnt), 32'b0010);
        apply_stimulus(0, 4'b0100, 0, 0);
        check_output("drop_gnt_b", 32'(bus.gnt), 32'b0100);
        apply_stimulus(0, 4'b0000, 0, 0);

`ifdef FIFO_WR_ARB_STATS_EN
        apply_stimulus(1, 4'b0000, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 4'b0001, 0, 0);
        apply_stimulus(0, 4'b0000, 0, 0);
        check_output("cnt0_10", 32'(grant_cnt[0]), 32'd10);
        check_output("cnt1_0", 32'(grant_cnt[1]), 32'd0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 4'b0001, 0, 0);
        apply_stimulus(0, 4'b0000, 0, 0);
        check_output("cnt0_sat", 32'(grant_cnt[0]), 32'd15);
`endif

        apply_stimulus(0, 4'b0000, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
